// File: rtl/cdc1_ctrl_pkg.sv
// Shared types and constants for the cdc1 bank drive controller.
// Optional shadow/skip feature is enabled by defining CDC1_CTRL_SHADOW_EN.
package cdc1_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DEAD  = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;

    // Idle levels of the cdc1 gates: pull-up (active-low) and pull-down (active-high) both off.
    localparam logic I1_OFF = 1'b1;
    localparam logic I2_OFF = 1'b0;

    localparam int MIN_PULSE = 1;
    localparam int MIN_DEAD  = 1;

endpackage

// File: rtl/cdc1_rr_arb.sv
// Round-robin arbiter: first requesting channel at or after ptr wins.
// Produces a one-hot grant, its index and a valid flag.
module cdc1_rr_arb
    import cdc1_ctrl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx,
    output logic           valid
);

    int j;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves a latch.
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) j = j - NCH;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cdc1_drive_ctrl.sv
// Sequencer/round-robin arbiter driving one cdc1 cell at a time with pulse + dead interval.
// Define CDC1_CTRL_SHADOW_EN to skip re-driving a cell already known to hold the target level.
module cdc1_drive_ctrl
    import cdc1_ctrl_pkg::*;
#(
    parameter int NCH = 4,
    parameter int PW  = 8,
    parameter int DW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] val,
    input  logic [PW-1:0]  pulse_len,
    input  logic [DW-1:0]  dead_len,
    output logic [NCH-1:0] ack,
    output logic           busy,
    output logic [NCH-1:0] i1,
    output logic [NCH-1:0] i2
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t         state, state_nxt;
    logic [IW-1:0]  ptr, ptr_nxt;
    logic [NCH-1:0] cur_gnt, cur_gnt_nxt;
    logic           cur_val, cur_val_nxt;
    logic [PW-1:0]  p_cnt, p_cnt_nxt;
    logic [DW-1:0]  d_cnt, d_cnt_nxt;
    logic [NCH-1:0] i1_nxt, i2_nxt, ack_nxt;
    logic           busy_nxt;

    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  arb_idx;
    logic           arb_valid;

    cdc1_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

`ifdef CDC1_CTRL_SHADOW_EN
    logic [NCH-1:0] vo_valid, vo_valid_nxt;
    logic [NCH-1:0] vo_est, vo_est_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cur_gnt_nxt = cur_gnt;
        cur_val_nxt = cur_val;
        p_cnt_nxt   = p_cnt;
        d_cnt_nxt   = d_cnt;
        i1_nxt      = {NCH{I1_OFF}};
        i2_nxt      = {NCH{I2_OFF}};
        ack_nxt     = '0;
`ifdef CDC1_CTRL_SHADOW_EN
        vo_valid_nxt = vo_valid;
        vo_est_nxt   = vo_est;
`endif
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    cur_gnt_nxt = arb_gnt;
                    cur_val_nxt = val[arb_idx];
                    ptr_nxt     = (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);
                    // Counters hold (len-1); a zero length behaves as the minimum.
                    p_cnt_nxt   = (pulse_len == '0) ? '0 : pulse_len - PW'(MIN_PULSE);
                    d_cnt_nxt   = (dead_len == '0) ? '0 : dead_len - DW'(MIN_DEAD);
`ifdef CDC1_CTRL_SHADOW_EN
                    if (vo_valid[arb_idx] && (vo_est[arb_idx] == val[arb_idx])) begin
                        state_nxt = ST_SKIP;
                        ack_nxt   = arb_gnt;
                    end else
`endif
                    begin
                        state_nxt = ST_DRIVE;
                        if (val[arb_idx]) i1_nxt = ~arb_gnt;
                        else              i2_nxt = arb_gnt;
                    end
                end
            end
            ST_DRIVE: begin
                if (p_cnt == '0) begin
                    state_nxt = ST_DEAD;
                    ack_nxt   = cur_gnt;
`ifdef CDC1_CTRL_SHADOW_EN
                    vo_valid_nxt = vo_valid | cur_gnt;
                    vo_est_nxt   = (vo_est & ~cur_gnt) | (cur_val ? cur_gnt : '0);
`endif
                end else begin
                    p_cnt_nxt = p_cnt - PW'(1);
                    if (cur_val) i1_nxt = ~cur_gnt;
                    else         i2_nxt = cur_gnt;
                end
            end
            ST_DEAD: begin
                if (d_cnt == '0) state_nxt = ST_IDLE;
                else             d_cnt_nxt = d_cnt - DW'(1);
            end
`ifdef CDC1_CTRL_SHADOW_EN
            ST_SKIP: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cur_gnt <= '0;
            cur_val <= 1'b0;
            p_cnt   <= '0;
            d_cnt   <= '0;
            i1      <= {NCH{I1_OFF}};
            i2      <= {NCH{I2_OFF}};
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            cur_gnt <= cur_gnt_nxt;
            cur_val <= cur_val_nxt;
            p_cnt   <= p_cnt_nxt;
            d_cnt   <= d_cnt_nxt;
            i1      <= i1_nxt;
            i2      <= i2_nxt;
            ack     <= ack_nxt;
            busy    <= busy_nxt;
        end
    end

`ifdef CDC1_CTRL_SHADOW_EN
    always_ff @(posedge clk) begin
        // NOTE: only vo_valid needs clearing; vo_est is ignored until its valid bit is set.
        if (rst) begin
            vo_valid <= '0;
        end else begin
            vo_valid <= vo_valid_nxt;
        end
        vo_est <= vo_est_nxt;
    end
`endif

endmodule
